// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
//   Shared definitions for the RV32I decode stage: widths, base opcodes,
//   bit positions of the one-hot instruction vector, the immediate-format
//   enum, the decoded-entry struct and the one-hot decode function.
//   Optional feature macro used elsewhere: INSTR_DECODER_ILLEGAL_FLAG_EN.
// -----------------------------------------------------------------------------
package decoder_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 39;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    // Bit positions inside the one-hot vector (fixed by the ALU encoding)
    localparam int IDX_ADD    = 0;
    localparam int IDX_SUB    = 1;
    localparam int IDX_XOR    = 2;
    localparam int IDX_OR     = 3;
    localparam int IDX_AND    = 4;
    localparam int IDX_SLL    = 5;
    localparam int IDX_SRL    = 6;
    localparam int IDX_SRA    = 7;
    localparam int IDX_SLT    = 8;
    localparam int IDX_SLTU   = 9;
    localparam int IDX_ADDI   = 10;
    localparam int IDX_XORI   = 11;
    localparam int IDX_ORI    = 12;
    localparam int IDX_ANDI   = 13;
    localparam int IDX_SLLI   = 14;
    localparam int IDX_SRLI   = 15;
    localparam int IDX_SRAI   = 16;
    localparam int IDX_SLTI   = 17;
    localparam int IDX_SLTIU  = 18;
    localparam int IDX_LB     = 19;
    localparam int IDX_LH     = 20;
    localparam int IDX_LW     = 21;
    localparam int IDX_LBU    = 22;
    localparam int IDX_LHU    = 23;
    localparam int IDX_SB     = 24;
    localparam int IDX_SH     = 25;
    localparam int IDX_SW     = 26;
    localparam int IDX_BEQ    = 27;
    localparam int IDX_BNE    = 28;
    localparam int IDX_BLT    = 29;
    localparam int IDX_BGE    = 30;
    localparam int IDX_BLTU   = 31;
    localparam int IDX_BGEU   = 32;
    localparam int IDX_JAL    = 33;
    localparam int IDX_JALR   = 34;
    localparam int IDX_LUI    = 35;
    localparam int IDX_AUIPC  = 36;
    localparam int IDX_ECALL  = 37;
    localparam int IDX_EBREAK = 38;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_t;

    // One decoded entry as held in the main and skid registers
    typedef struct packed {
        logic [INSTR_W-1:0] instructions;
        logic [4:0]         rs1_addr;
        logic [4:0]         rs2_addr;
        logic [4:0]         rd_addr;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
    } entry_t;

    // Full decode to a one-hot vector; all-zero means no legal match.
    function automatic logic [INSTR_W-1:0] decode_onehot(input logic [31:0] w);
        logic [INSTR_W-1:0] v;
        logic [6:0]         opc;
        logic [2:0]         f3;
        logic [6:0]         f7;
        v   = '0;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        case (opc)
            OP: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: v[IDX_ADD]  = 1'b1;
                        3'd1: v[IDX_SLL]  = 1'b1;
                        3'd2: v[IDX_SLT]  = 1'b1;
                        3'd3: v[IDX_SLTU] = 1'b1;
                        3'd4: v[IDX_XOR]  = 1'b1;
                        3'd5: v[IDX_SRL]  = 1'b1;
                        3'd6: v[IDX_OR]   = 1'b1;
                        default: v[IDX_AND] = 1'b1;
                    endcase
                end else if (f7 == 7'h20) begin
                    if (f3 == 3'd0) v[IDX_SUB] = 1'b1;
                    if (f3 == 3'd5) v[IDX_SRA] = 1'b1;
                end
            end
            OP_IMM: begin
                case (f3)
                    3'd0: v[IDX_ADDI]  = 1'b1;
                    3'd2: v[IDX_SLTI]  = 1'b1;
                    3'd3: v[IDX_SLTIU] = 1'b1;
                    3'd4: v[IDX_XORI]  = 1'b1;
                    3'd6: v[IDX_ORI]   = 1'b1;
                    3'd7: v[IDX_ANDI]  = 1'b1;
                    3'd1: if (f7 == 7'h00) v[IDX_SLLI] = 1'b1;
                    default: begin
                        if (f7 == 7'h00)      v[IDX_SRLI] = 1'b1;
                        else if (f7 == 7'h20) v[IDX_SRAI] = 1'b1;
                    end
                endcase
            end
            LOAD: begin
                case (f3)
                    3'd0: v[IDX_LB]  = 1'b1;
                    3'd1: v[IDX_LH]  = 1'b1;
                    3'd2: v[IDX_LW]  = 1'b1;
                    3'd4: v[IDX_LBU] = 1'b1;
                    3'd5: v[IDX_LHU] = 1'b1;
                    default: ;
                endcase
            end
            STORE: begin
                case (f3)
                    3'd0: v[IDX_SB] = 1'b1;
                    3'd1: v[IDX_SH] = 1'b1;
                    3'd2: v[IDX_SW] = 1'b1;
                    default: ;
                endcase
            end
            BRANCH: begin
                case (f3)
                    3'd0: v[IDX_BEQ]  = 1'b1;
                    3'd1: v[IDX_BNE]  = 1'b1;
                    3'd4: v[IDX_BLT]  = 1'b1;
                    3'd5: v[IDX_BGE]  = 1'b1;
                    3'd6: v[IDX_BLTU] = 1'b1;
                    3'd7: v[IDX_BGEU] = 1'b1;
                    default: ;
                endcase
            end
            JAL:   v[IDX_JAL] = 1'b1;
            JALR:  if (f3 == 3'd0) v[IDX_JALR] = 1'b1;
            LUI:   v[IDX_LUI] = 1'b1;
            AUIPC: v[IDX_AUIPC] = 1'b1;
            SYSTEM: begin
                // ecall/ebreak only when every field except imm[0] is zero
                if (w[31:7] == 25'h0000000)      v[IDX_ECALL]  = 1'b1;
                else if (w[31:7] == 25'h0002000) v[IDX_EBREAK] = 1'b1;
            end
            default: ;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/instr_decoder_if.sv
// -----------------------------------------------------------------------------
// instr_decoder_if
//   Bundles the fetch-side handshake (in_valid/in_ready/instr_in/pc_in) and the
//   decoded-side handshake (out_valid/out_ready plus decoded payload).
//   Modports: slave  - the decode stage itself
//             master - the surrounding environment (fetch + consumer)
//   The illegal signal exists only with INSTR_DECODER_ILLEGAL_FLAG_EN.
// -----------------------------------------------------------------------------
interface instr_decoder_if;
    import decoder_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [31:0]         instr_in;
    logic [XLEN-1:0]     pc_in;
    logic                out_valid;
    logic                out_ready;
    logic [INSTR_W-1:0]  instructions;
    logic [4:0]          rs1_addr;
    logic [4:0]          rs2_addr;
    logic [4:0]          rd_addr;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     pc_out;
`ifdef INSTR_DECODER_ILLEGAL_FLAG_EN
    logic                illegal;
`endif

    modport slave (
        input  in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, instructions, rs1_addr, rs2_addr, rd_addr,
               imm, pc_out
`ifdef INSTR_DECODER_ILLEGAL_FLAG_EN
        , output illegal
`endif
    );

    modport master (
        output in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, instructions, rs1_addr, rs2_addr, rd_addr,
               imm, pc_out
`ifdef INSTR_DECODER_ILLEGAL_FLAG_EN
        , input illegal
`endif
    );

endinterface

// File: rtl/instr_decoder_imm_gen.sv
// -----------------------------------------------------------------------------
// instr_decoder_imm_gen
//   Combinational immediate generator: picks the RV32I format from the opcode
//   and sign-extends to XLEN. R-type and unknown opcodes give 0.
//   Ports: instr (in, 32)  raw instruction word
//          imm   (out, XLEN) sign-extended immediate
// -----------------------------------------------------------------------------
module instr_decoder_imm_gen
    import decoder_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    imm_fmt_t fmt;

    always_comb begin
        fmt = FMT_R;
        case (instr[6:0])
            OP_IMM, LOAD, JALR, SYSTEM: fmt = FMT_I;
            STORE:                      fmt = FMT_S;
            BRANCH:                     fmt = FMT_B;
            LUI, AUIPC:                 fmt = FMT_U;
            JAL:                        fmt = FMT_J;
            default:                    fmt = FMT_R;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'h000};
            FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
//   Registered RV32I decode stage with a one-entry skid buffer. A main register
//   (M) drives the outputs; a skid register (S) catches the word accepted while
//   M is stalled, so in_ready depends only on registered state.
//   Ports: clk    (in)  rising-edge clock
//          rst_n  (in)  synchronous active-low reset
//          flush  (in)  drop every held entry at the next edge
//          bus    (instr_decoder_if.slave) fetch and decoded handshakes
//   Macro INSTR_DECODER_ILLEGAL_FLAG_EN: when defined, illegal words are
//   forwarded with bus.illegal=1; otherwise they are consumed and discarded.
// -----------------------------------------------------------------------------
module instr_decoder
    import decoder_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    instr_decoder_if.slave bus
);

    entry_t dec_entry;
    logic   accept;
    logic   drain;
    logic   store_ok;

    logic   m_valid_reg, m_valid_next;
    logic   s_valid_reg, s_valid_next;
    entry_t m_entry_reg, m_entry_next;
    entry_t s_entry_reg, s_entry_next;

    logic [XLEN-1:0] dec_imm;

    instr_decoder_imm_gen u_imm_gen (
        .instr (bus.instr_in),
        .imm   (dec_imm)
    );

    always_comb begin
        dec_entry              = '0;
        dec_entry.instructions = decode_onehot(bus.instr_in);
        dec_entry.rs1_addr     = bus.instr_in[19:15];
        dec_entry.rs2_addr     = bus.instr_in[24:20];
        dec_entry.rd_addr      = bus.instr_in[11:7];
        dec_entry.imm          = dec_imm;
        dec_entry.pc           = bus.pc_in;
    end

    assign accept = bus.in_valid && !s_valid_reg;
    assign drain  = m_valid_reg && bus.out_ready;

`ifdef INSTR_DECODER_ILLEGAL_FLAG_EN
    assign store_ok = accept;
`else
    // Illegal words still complete the handshake but are never stored
    assign store_ok = accept && (dec_entry.instructions != '0);
`endif

    always_comb begin
        m_valid_next = m_valid_reg;
        s_valid_next = s_valid_reg;
        m_entry_next = m_entry_reg;
        s_entry_next = s_entry_reg;
        if (flush) begin
            m_valid_next = 1'b0;
            s_valid_next = 1'b0;
        end else if (!m_valid_reg || drain) begin
            // M frees up: the older skid entry has priority. When S is full
            // in_ready is low, so no new word competes with it.
            if (s_valid_reg) begin
                m_valid_next = 1'b1;
                m_entry_next = s_entry_reg;
                s_valid_next = 1'b0;
            end else if (store_ok) begin
                m_valid_next = 1'b1;
                m_entry_next = dec_entry;
            end else begin
                m_valid_next = 1'b0;
            end
        end else if (store_ok) begin
            s_valid_next = 1'b1;
            s_entry_next = dec_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_reg <= 1'b0;
            s_valid_reg <= 1'b0;
            m_entry_reg <= '0;
            s_entry_reg <= '0;
        end else begin
            m_valid_reg <= m_valid_next;
            s_valid_reg <= s_valid_next;
            m_entry_reg <= m_entry_next;
            s_entry_reg <= s_entry_next;
        end
    end

    assign bus.in_ready     = !s_valid_reg;
    assign bus.out_valid    = m_valid_reg;
    assign bus.instructions = m_entry_reg.instructions;
    assign bus.rs1_addr     = m_entry_reg.rs1_addr;
    assign bus.rs2_addr     = m_entry_reg.rs2_addr;
    assign bus.rd_addr      = m_entry_reg.rd_addr;
    assign bus.imm          = m_entry_reg.imm;
    assign bus.pc_out       = m_entry_reg.pc;
`ifdef INSTR_DECODER_ILLEGAL_FLAG_EN
    // An entry with no legal match carries an all-zero vector
    assign bus.illegal      = m_valid_reg && (m_entry_reg.instructions == '0);
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// -----------------------------------------------------------------------------
// tb_instr_decoder
//   Directed-vector bench for instr_decoder; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_instr_decoder;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    int test_count = 0;
    int fail_count = 0;

    instr_decoder_if bus ();

    instr_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Single word through an idle stage with out_ready=1
    task automatic run_vec(input string tag, input logic [31:0] w, input logic [31:0] pc,
                           input logic [38:0] exp_i, input logic [31:0] exp_imm);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr_in  = w;
        bus.pc_in     = pc;
        step();
        bus.in_valid  = 1'b0;
        check({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, " instructions"}, 64'(bus.instructions), 64'(exp_i));
        check({tag, " imm"}, 64'(bus.imm), 64'(exp_imm));
        check({tag, " pc_out"}, 64'(bus.pc_out), 64'(pc));
        check({tag, " rd"}, 64'(bus.rd_addr), 64'(w[11:7]));
        check({tag, " rs1"}, 64'(bus.rs1_addr), 64'(w[19:15]));
        check({tag, " rs2"}, 64'(bus.rs2_addr), 64'(w[24:20]));
`ifdef INSTR_DECODER_ILLEGAL_FLAG_EN
        check({tag, " illegal"}, 64'(bus.illegal), 64'd0);
`endif
        step();
        check({tag, " drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic run_illegal(input string tag, input logic [31:0] w);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr_in  = w;
        bus.pc_in     = 32'h0000_0500;
        step();
        bus.in_valid  = 1'b0;
        check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
`ifdef INSTR_DECODER_ILLEGAL_FLAG_EN
        check({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, " illegal"}, 64'(bus.illegal), 64'd1);
        check({tag, " instructions"}, 64'(bus.instructions), 64'd0);
`else
        check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
`endif
        step();
        check({tag, " drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    // Leaves M=A (pc 0x300) stalled and S=B (pc 0x304) full
    task automatic fill_m_and_s();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr_in  = 32'h002081B3;
        bus.pc_in     = 32'h0000_0300;
        step();
        bus.instr_in  = 32'h40208033;
        bus.pc_in     = 32'h0000_0304;
        step();
        bus.in_valid  = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, " instructions"}, 64'(bus.instructions), 64'd0);
        check({tag, " imm"}, 64'(bus.imm), 64'd0);
        check({tag, " pc_out"}, 64'(bus.pc_out), 64'd0);
        check({tag, " rd"}, 64'(bus.rd_addr), 64'd0);
        check({tag, " rs1"}, 64'(bus.rs1_addr), 64'd0);
        check({tag, " rs2"}, 64'(bus.rs2_addr), 64'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr_in  = 32'h0;
        bus.pc_in     = 32'h0;
        bus.out_ready = 1'b0;

        // Reset
        step();
        step();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        step();
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_valid idle", 64'(bus.out_valid), 64'd0);

        // Directed decode vectors
        run_vec("add",    32'h002081B3, 32'h0000_0100, 39'h1,            32'h0000_0000);
        run_vec("sub",    32'h40208033, 32'h0000_0104, 39'h2,            32'h0000_0000);
        run_vec("and",    32'h0020F1B3, 32'h0000_0108, 39'h10,           32'h0000_0000);
        run_vec("addi",   32'hFFF00093, 32'h0000_010C, 39'h400,          32'hFFFF_FFFF);
        run_vec("srai",   32'h40105093, 32'h0000_0110, 39'h10000,        32'h0000_0401);
        run_vec("lw",     32'h00812283, 32'h0000_0114, 39'h200000,       32'h0000_0008);
        run_vec("sw",     32'hFE312E23, 32'h0000_0118, 39'h4000000,      32'hFFFF_FFFC);
        run_vec("beq",    32'hFE208CE3, 32'h0000_011C, 39'h8000000,      32'hFFFF_FFF8);
        run_vec("jal",    32'h010000EF, 32'h0000_0120, 39'h2_0000_0000,  32'h0000_0010);
        run_vec("jalr",   32'h004100E7, 32'h0000_0124, 39'h4_0000_0000,  32'h0000_0004);
        run_vec("lui",    32'h123452B7, 32'h0000_0128, 39'h8_0000_0000,  32'h1234_5000);
        run_vec("auipc",  32'hFFFFF017, 32'h0000_012C, 39'h10_0000_0000, 32'hFFFF_F000);
        run_vec("ecall",  32'h00000073, 32'h0000_0130, 39'h20_0000_0000, 32'h0000_0000);
        run_vec("ebreak", 32'h00100073, 32'h0000_0134, 39'h40_0000_0000, 32'h0000_0001);

        // Illegal words
        run_illegal("ill_ones",  32'hFFFFFFFF);
        run_illegal("ill_ecall", 32'h000000F3);
        run_illegal("ill_f7",    32'h022081B3);

        // Backpressure: A, B, C back-to-back, out_ready low for two cycles
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr_in  = 32'h002081B3;
        bus.pc_in     = 32'h0000_0200;
        step();
        check("bp A in M", 64'(bus.pc_out), 64'h200);
        check("bp in_ready after A", 64'(bus.in_ready), 64'd1);
        bus.instr_in  = 32'h40208033;
        bus.pc_in     = 32'h0000_0204;
        step();
        check("bp in_ready after B", 64'(bus.in_ready), 64'd0);
        check("bp A held", 64'(bus.pc_out), 64'h200);
        bus.instr_in  = 32'h0020F1B3;
        bus.pc_in     = 32'h0000_0208;
        step();
        check("bp stall valid", 64'(bus.out_valid), 64'd1);
        check("bp stall pc", 64'(bus.pc_out), 64'h200);
        check("bp stall instr", 64'(bus.instructions), 64'h1);
        bus.out_ready = 1'b1;
        step();
        check("bp B out pc", 64'(bus.pc_out), 64'h204);
        check("bp B out instr", 64'(bus.instructions), 64'h2);
        check("bp in_ready reopen", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid  = 1'b0;
        check("bp C out pc", 64'(bus.pc_out), 64'h208);
        check("bp C out instr", 64'(bus.instructions), 64'h10);
        check("bp C valid", 64'(bus.out_valid), 64'd1);
        step();
        check("bp empty", 64'(bus.out_valid), 64'd0);

        // Illegal word arriving while M is stalled is consumed, not queued
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr_in  = 32'h002081B3;
        bus.pc_in     = 32'h0000_0400;
        step();
        bus.instr_in  = 32'hFFFFFFFF;
        bus.pc_in     = 32'h0000_0404;
        step();
        bus.in_valid  = 1'b0;
`ifdef INSTR_DECODER_ILLEGAL_FLAG_EN
        check("stall ill in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        step();
        check("stall ill fwd pc", 64'(bus.pc_out), 64'h404);
        check("stall ill fwd flag", 64'(bus.illegal), 64'd1);
        step();
`else
        check("stall ill in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        step();
`endif
        check("stall ill empty", 64'(bus.out_valid), 64'd0);

        // Flush with M and S full and a word offered
        fill_m_and_s();
        check("flush pre S full", 64'(bus.in_ready), 64'd0);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr_in  = 32'h0020F1B3;
        bus.pc_in     = 32'h0000_0308;
        step();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        check("flush out_valid", 64'(bus.out_valid), 64'd0);
        check("flush in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        step();
        check("flush nothing after", 64'(bus.out_valid), 64'd0);

        // Flush beats an accept into an empty stage
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr_in  = 32'h002081B3;
        bus.pc_in     = 32'h0000_0310;
        step();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        check("flush drops accept", 64'(bus.out_valid), 64'd0);

        // Reset while stalled with S full
        fill_m_and_s();
        check("rst pre valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_zero_outputs("rst mid");
        check("rst mid in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        step();
        check("rst after valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
